vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_timing.sv | 107 ++++++++++
 tb/tb_vga_timing.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// VGA raster timing generator: free-running pixel/line counters, sync and
// blanking decode, and a one-cycle registered output stage that merges the
// renderer colour with the sync terms so every DAC signal is aligned.
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_r_data,
  input  logic [7:0] i_g_data,
  input  logic [7:0] i_b_data,
  output logic [9:0] o_x_cnt,
  output logic [9:0] o_y_cnt,
  output logic       o_active,
  output logic       o_frame_start,
  output logic [7:0] o_VGA_R,
  output logic [7:0] o_VGA_G,
  output logic [7:0] o_VGA_B,
  output logic       o_VGA_HS,
  output logic       o_VGA_VS,
  output logic       o_VGA_BLANK_N,
  output logic       o_VGA_SYNC_N,
  output logic       o_VGA_CLK
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Geometry boundaries in counter width so all compares are 10-bit
  localparam logic [9:0] H_MAX        = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX        = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS        = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS        = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_wrap;
  logic       active;
  logic       hs_term;
  logic       vs_term;

  assign h_wrap = (h_cnt == H_MAX);

  // Pixel counter wraps every line; line counter steps only on that wrap
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      if (v_cnt == V_MAX) begin
        v_cnt <= '0;
      end else begin
        v_cnt <= v_cnt + 10'd1;
      end
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Visible-area and active-low sync decode of the current counter position
  always_comb begin
    active  = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    hs_term = !((h_cnt >= H_SYNC_FIRST) && (h_cnt <= H_SYNC_LAST));
    vs_term = !((v_cnt >= V_SYNC_FIRST) && (v_cnt <= V_SYNC_LAST));
  end

  assign o_x_cnt       = h_cnt;
  assign o_y_cnt       = v_cnt;
  assign o_active      = active;
  assign o_frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);

  // Output stage: colour, syncs and blanking registered together; colour is
  // zeroed outside the visible area so the DAC never sees porch/sync data
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_VGA_R       <= 8'h00;
      o_VGA_G       <= 8'h00;
      o_VGA_B       <= 8'h00;
      o_VGA_HS      <= 1'b1;
      o_VGA_VS      <= 1'b1;
      o_VGA_BLANK_N <= 1'b0;
    end else begin
      o_VGA_R       <= active ? i_r_data : 8'h00;
      o_VGA_G       <= active ? i_g_data : 8'h00;
      o_VGA_B       <= active ? i_b_data : 8'h00;
      o_VGA_HS      <= hs_term;
      o_VGA_VS      <= vs_term;
      o_VGA_BLANK_N <= active;
    end
  end

  assign o_VGA_SYNC_N = 1'b0;
  assign o_VGA_CLK    = ~i_clk;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: one instance with the standard 640x480 geometry for
// line-level behaviour, one with a tiny geometry so whole frames fit easily.
module tb_vga_timing;

  localparam int S_HA = 16, S_HFP = 2, S_HS = 3, S_HBP = 2;
  localparam int S_VA = 8,  S_VFP = 2, S_VS = 2, S_VBP = 3;

  logic clk = 1'b0;
  logic rst0_n = 1'b0;
  logic rst1_n = 1'b0;
  logic [7:0] r0 = 8'h00, g0 = 8'h00, b0 = 8'h00;
  logic [7:0] r1 = 8'h00, g1 = 8'h00, b1 = 8'h00;

  logic [9:0] x0, y0, x1, y1;
  logic       act0, fs0, hs0, vs0, bl0, sn0, vc0;
  logic       act1, fs1, hs1, vs1, bl1, sn1, vc1;
  logic [7:0] vr0, vg0, vb0, vr1, vg1, vb1;

  vga_timing dut0 (
    .i_clk(clk), .i_rst_n(rst0_n),
    .i_r_data(r0), .i_g_data(g0), .i_b_data(b0),
    .o_x_cnt(x0), .o_y_cnt(y0), .o_active(act0), .o_frame_start(fs0),
    .o_VGA_R(vr0), .o_VGA_G(vg0), .o_VGA_B(vb0),
    .o_VGA_HS(hs0), .o_VGA_VS(vs0), .o_VGA_BLANK_N(bl0),
    .o_VGA_SYNC_N(sn0), .o_VGA_CLK(vc0)
  );

  vga_timing #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
  ) dut1 (
    .i_clk(clk), .i_rst_n(rst1_n),
    .i_r_data(r1), .i_g_data(g1), .i_b_data(b1),
    .o_x_cnt(x1), .o_y_cnt(y1), .o_active(act1), .o_frame_start(fs1),
    .o_VGA_R(vr1), .o_VGA_G(vg1), .o_VGA_B(vb1),
    .o_VGA_HS(hs1), .o_VGA_VS(vs1), .o_VGA_BLANK_N(bl1),
    .o_VGA_SYNC_N(sn1), .o_VGA_CLK(vc1)
  );

  // 25 MHz pixel clock
  always #20 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int sel = 0;
  int k = 0;
  int ha, hfp, hsw, hbp, va, vfp, vsw, vbp;
  logic [7:0] cur_r, cur_g, cur_b, prev_r, prev_g, prev_b;

  logic [9:0] x, y;
  logic       act, fs, hs, vs, blank_n, sync_n, vclk;
  logic [7:0] vr, vg, vb;

  // Observation mux onto whichever instance the current test targets
  always_comb begin
    if (sel == 0) begin
      x = x0; y = y0; act = act0; fs = fs0; hs = hs0; vs = vs0;
      blank_n = bl0; sync_n = sn0; vclk = vc0; vr = vr0; vg = vg0; vb = vb0;
    end else begin
      x = x1; y = y1; act = act1; fs = fs1; hs = hs1; vs = vs1;
      blank_n = bl1; sync_n = sn1; vclk = vc1; vr = vr1; vg = vg1; vb = vb1;
    end
  end

  task automatic use_dut(input int s);
    sel = s;
    if (s == 0) begin
      ha = 640; hfp = 16; hsw = 96; hbp = 48; va = 480; vfp = 10; vsw = 2; vbp = 33;
    end else begin
      ha = S_HA; hfp = S_HFP; hsw = S_HS; hbp = S_HBP;
      va = S_VA; vfp = S_VFP; vsw = S_VS; vbp = S_VBP;
    end
  endtask

  // Reference: position p cycles after reset release, from raster arithmetic
  function automatic void model(input int p, output int h, output int v,
                                output logic a, output logic hsn, output logic vsn);
    int htot, vtot;
    htot = ha + hfp + hsw + hbp;
    vtot = va + vfp + vsw + vbp;
    h   = p % htot;
    v   = (p / htot) % vtot;
    a   = (h < ha) && (v < va);
    hsn = !((h >= ha + hfp) && (h < ha + hfp + hsw));
    vsn = !((v >= va + vfp) && (v < va + vfp + vsw));
  endfunction

  task automatic set_colour(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    cur_r = r; cur_g = g; cur_b = b;
    if (sel == 0) begin r0 = r; g0 = g; b0 = b; end
    else begin r1 = r; g1 = g; b1 = b; end
  endtask

  task automatic set_reset(input logic v);
    if (sel == 0) rst0_n = v;
    else rst1_n = v;
  endtask

  // Advance one clock; sample point is the following falling edge
  task automatic tick();
    @(negedge clk);
    k++;
    prev_r = cur_r; prev_g = cur_g; prev_b = cur_b;
  endtask

  task automatic applyReset(input int n);
    set_reset(1'b0);
    repeat (n) @(negedge clk);
    set_reset(1'b1);
    k = 0;
  endtask

  task automatic test_reset();
    use_dut(0);
    set_colour(8'hFF, 8'hFF, 8'hFF);
    set_reset(1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (vr !== 8'h00 || vg !== 8'h00 || vb !== 8'h00 || hs !== 1'b1 || vs !== 1'b1 || blank_n !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got rgb=%h/%h/%h hs=%b vs=%b blank_n=%b want 0/0/0 1 1 0",
               vr, vg, vb, hs, vs, blank_n);
    end
    checks++;
    if (sync_n !== 1'b0 || vclk !== ~clk) begin
      errors++;
      $display("[TB] FAIL reset_sync_clk got sync_n=%b vga_clk=%b want 0 %b", sync_n, vclk, ~clk);
    end
    set_reset(1'b1);
    k = 0;
    checks++;
    if (x !== 10'd0 || y !== 10'd0 || fs !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release got x=%0d y=%0d fs=%b want 0 0 1", x, y, fs);
    end
  endtask

  task automatic test_line_counting();
    int h, v, ph, pv;
    logic a, hsn, vsn, pa, phs, pvs;
    for (int i = 1; i <= 801; i++) begin
      set_colour(8'($urandom), 8'($urandom), 8'($urandom));
      tick();
      model(k, h, v, a, hsn, vsn);
      model(k - 1, ph, pv, pa, phs, pvs);
      checks++;
      if (x !== 10'(h) || y !== 10'(v)) begin
        errors++;
        $display("[TB] FAIL line_count k=%0d got x=%0d y=%0d want x=%0d y=%0d", k, x, y, h, v);
      end
      checks++;
      if (act !== a || fs !== ((h == 0) && (v == 0))) begin
        errors++;
        $display("[TB] FAIL line_decode k=%0d got active=%b fs=%b want %b %b", k, act, fs, a, (h == 0) && (v == 0));
      end
      checks++;
      if (hs !== phs || vs !== pvs || blank_n !== pa) begin
        errors++;
        $display("[TB] FAIL line_sync k=%0d got hs=%b vs=%b blank_n=%b want %b %b %b", k, hs, vs, blank_n, phs, pvs, pa);
      end
      checks++;
      if (vr !== (pa ? prev_r : 8'h00) || vg !== (pa ? prev_g : 8'h00) || vb !== (pa ? prev_b : 8'h00)) begin
        errors++;
        $display("[TB] FAIL line_colour k=%0d got %h/%h/%h want %h/%h/%h", k, vr, vg, vb,
                 pa ? prev_r : 8'h00, pa ? prev_g : 8'h00, pa ? prev_b : 8'h00);
      end
    end
  endtask

  task automatic align_to_line();
    for (int n = 0; n < 1000 && x !== 10'd0; n++) tick();
    checks++;
    if (x !== 10'd0) begin
      errors++;
      $display("[TB] FAIL line_align got x=%0d want 0 within 1000 cycles", x);
    end
  endtask

  task automatic test_hsync();
    int low_cnt, fall;
    logic last_hs;
    use_dut(0);
    align_to_line();
    for (int line = 0; line < 2; line++) begin
      low_cnt = 0;
      fall = -1;
      last_hs = hs;
      for (int i = 1; i <= 800; i++) begin
        set_colour(8'($urandom), 8'($urandom), 8'($urandom));
        tick();
        if (hs === 1'b0) low_cnt++;
        if (last_hs === 1'b1 && hs === 1'b0) fall = i;
        last_hs = hs;
      end
      checks++;
      if (low_cnt != hsw) begin
        errors++;
        $display("[TB] FAIL hsync_width line=%0d got %0d want %0d", line, low_cnt, hsw);
      end
      checks++;
      if (fall != ha + hfp + 1) begin
        errors++;
        $display("[TB] FAIL hsync_edge line=%0d got %0d want %0d", line, fall, ha + hfp + 1);
      end
    end
  endtask

  task automatic test_colour_gating();
    int ff_cnt, bl_cnt, bad;
    use_dut(0);
    align_to_line();
    for (int line = 0; line < 2; line++) begin
      ff_cnt = 0; bl_cnt = 0; bad = 0;
      for (int i = 1; i <= 800; i++) begin
        set_colour(8'hFF, 8'($urandom), 8'($urandom));
        tick();
        if (vr === 8'hFF) ff_cnt++;
        if (blank_n === 1'b1) bl_cnt++;
        if (blank_n === 1'b1 && vr !== 8'hFF) bad++;
        if (blank_n !== 1'b1 && (vr !== 8'h00 || vg !== 8'h00 || vb !== 8'h00)) bad++;
      end
      checks++;
      if (ff_cnt != ha || bl_cnt != ha) begin
        errors++;
        $display("[TB] FAIL gating_count line=%0d got red=%0d blank_n=%0d want %0d", line, ff_cnt, bl_cnt, ha);
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("[TB] FAIL gating_level line=%0d got %0d bad cycles want 0", line, bad);
      end
    end
  endtask

  task automatic test_colour_follows_x();
    int h, v, ph, pv;
    logic a, hsn, vsn, pa, phs, pvs;
    logic [7:0] exp_r;
    int bad;
    use_dut(0);
    bad = 0;
    for (int i = 0; i < 800; i++) begin
      set_colour(x[7:0], 8'h00, 8'h00);
      tick();
      model(k - 1, ph, pv, pa, phs, pvs);
      exp_r = pa ? 8'(ph) : 8'h00;
      if (vr !== exp_r) begin
        bad++;
        if (bad < 4) $display("[TB] FAIL follow_x k=%0d got %h want %h", k, vr, exp_r);
      end
      model(k, h, v, a, hsn, vsn);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL follow_x_total got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_full_frame();
    int h, v, ph, pv, htot, vtot, vs_low, last_fs, wraps, bad;
    logic a, hsn, vsn, pa, phs, pvs;
    logic [9:0] last_y;
    use_dut(1);
    htot = ha + hfp + hsw + hbp;
    vtot = va + vfp + vsw + vbp;
    applyReset(2);
    vs_low = 0; last_fs = 0; wraps = 0; bad = 0;
    last_y = y;
    for (int i = 1; i <= 2 * htot * vtot + 3; i++) begin
      set_colour(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom), 8'($urandom), 8'($urandom));
      tick();
      model(k, h, v, a, hsn, vsn);
      model(k - 1, ph, pv, pa, phs, pvs);
      if (x !== 10'(h) || y !== 10'(v) || act !== a) bad++;
      if (hs !== phs || vs !== pvs || blank_n !== pa) bad++;
      if (vr !== (pa ? prev_r : 8'h00) || vg !== (pa ? prev_g : 8'h00) || vb !== (pa ? prev_b : 8'h00)) bad++;
      if (i <= htot * vtot && vs === 1'b0) vs_low++;
      if (fs === 1'b1) begin
        checks++;
        if (k - last_fs != htot * vtot) begin
          errors++;
          $display("[TB] FAIL frame_spacing got %0d want %0d", k - last_fs, htot * vtot);
        end
        last_fs = k;
      end
      if (last_y == 10'(vtot - 1) && y !== 10'(vtot - 1)) begin
        wraps++;
        checks++;
        if (y !== 10'd0) begin
          errors++;
          $display("[TB] FAIL frame_wrap got y=%0d want 0", y);
        end
      end
      last_y = y;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL frame_model got %0d bad cycles want 0", bad);
    end
    checks++;
    if (vs_low != vsw * htot) begin
      errors++;
      $display("[TB] FAIL vsync_width got %0d want %0d", vs_low, vsw * htot);
    end
    checks++;
    if (wraps != 2) begin
      errors++;
      $display("[TB] FAIL frame_wrap_count got %0d want 2", wraps);
    end
  endtask

  task automatic test_mid_sync_reset();
    int target, htot;
    use_dut(1);
    htot = ha + hfp + hsw + hbp;
    applyReset(2);
    target = (va + vfp + 1) * htot + (ha + hfp + 1);
    set_colour(8'hAA, 8'h55, 8'h11);
    while (k < target + 1) tick();
    checks++;
    if (hs !== 1'b0 || vs !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_pre got hs=%b vs=%b want 0 0", hs, vs);
    end
    set_reset(1'b0);
    @(negedge clk);
    checks++;
    if (hs !== 1'b1 || vs !== 1'b1 || blank_n !== 1'b0 || vr !== 8'h00) begin
      errors++;
      $display("[TB] FAIL midreset_edge got hs=%b vs=%b blank_n=%b r=%h want 1 1 0 00", hs, vs, blank_n, vr);
    end
    repeat (2) @(negedge clk);
    set_reset(1'b1);
    k = 0;
    checks++;
    if (x !== 10'd0 || y !== 10'd0 || fs !== 1'b1 || vclk !== ~clk) begin
      errors++;
      $display("[TB] FAIL midreset_release got x=%0d y=%0d fs=%b vga_clk=%b want 0 0 1 %b", x, y, fs, vclk, ~clk);
    end
    repeat (5) tick();
    checks++;
    if (x !== 10'd5 || y !== 10'd0 || fs !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_resume got x=%0d y=%0d fs=%b want 5 0 0", x, y, fs);
    end
  endtask

  // Watchdog so the run always ends even if a loop never completes
  initial begin
    #(40 * 30000);
    $display("[TB] FAIL watchdog expired");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] timeout");
  end

  // Run the scenarios in sequence and report
  initial begin
    use_dut(0);
    cur_r = 8'h00; cur_g = 8'h00; cur_b = 8'h00;
    prev_r = 8'h00; prev_g = 8'h00; prev_b = 8'h00;
    @(negedge clk);
    rst1_n = 1'b0;
    test_reset();
    test_line_counting();
    test_hsync();
    test_colour_gating();
    test_colour_follows_x();
    test_full_frame();
    test_mid_sync_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
